// File: rtl/ir_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_ctrl
// Brief    : Validates IR frames, holds a one-hot move direction and turns
//            shoot/start keys into req/ack handshakes with a shoot cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_ctrl #(
    parameter int unsigned COOLDOWN  = 2500000,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_SHOOT = 8'h05,
    parameter logic [7:0]  KEY_RIGHT = 8'h06,
    parameter logic [7:0]  KEY_STOP  = 8'h02,
    parameter logic [7:0]  KEY_START = 8'h08
) (
    input  logic        master_clk,
    input  logic        resetn,
    input  logic        ir_ready,
    input  logic [31:0] ir_data,
    input  logic        cmd_ack,
    output logic        left,
    output logic        right,
    output logic        stop,
    output logic        shoot_req,
    output logic        start_req,
    output logic [7:0]  err_count
);

    localparam int unsigned      CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHOOT_REQ = 3'd1,
        ST_START_REQ = 3'd2,
        ST_WAIT_REL  = 3'd3,
        ST_COOLDOWN  = 3'd4
    } state_t;

    state_t           state_q, state_d, state_ack;
    logic             ready_q;
    logic [2:0]       dir_q, dir_d;
    logic [7:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             last_shoot_q, last_shoot_d;

    logic [7:0] key;
    logic       frame_evt, frame_ok, valid_evt, bad_evt, is_shoot, is_start;
    logic       unused_custom;

    assign key       = ir_data[23:16];
    assign frame_evt = ir_ready & ~ready_q;
    assign frame_ok  = (ir_data[31:24] == ~key) &&
                       ((key == KEY_LEFT) || (key == KEY_SHOOT) || (key == KEY_RIGHT) ||
                        (key == KEY_STOP) || (key == KEY_START));
    assign valid_evt = frame_evt & frame_ok;
    assign bad_evt   = frame_evt & ~frame_ok;
    assign is_shoot  = valid_evt && (key == KEY_SHOOT);
    assign is_start  = valid_evt && (key == KEY_START);
    assign unused_custom = ^ir_data[15:0];

    always_comb begin
        dir_d = dir_q;
        err_d = err_q;
        if (valid_evt) begin
            if (key == KEY_LEFT)       dir_d = 3'b001;
            else if (key == KEY_RIGHT) dir_d = 3'b010;
            else                       dir_d = 3'b100;
        end
        if (bad_evt && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Two-step next state: ack/timer transitions first, then the frame event
    // is judged against that intermediate state.
    always_comb begin
        state_ack    = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        last_shoot_d = last_shoot_q;
        case (state_q)
            ST_SHOOT_REQ: if (cmd_ack) state_ack = ST_WAIT_REL;
            ST_START_REQ: if (cmd_ack) state_ack = ST_WAIT_REL;
            ST_WAIT_REL: begin
                if (!cmd_ack) begin
                    if (last_shoot_q) begin
                        state_ack = ST_COOLDOWN;
                        cnt_d     = CNT_LOAD;
                    end else begin
                        state_ack = ST_IDLE;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == '0) state_ack = ST_IDLE;
                else             cnt_d     = cnt_q - CNT_ONE;
            end
            default: ;
        endcase

        state_d = state_ack;
        case (state_ack)
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d       = 1'b0;
                    state_d      = ST_START_REQ;
                    last_shoot_d = 1'b0;
                end else if (is_start) begin
                    state_d      = ST_START_REQ;
                    last_shoot_d = 1'b0;
                end else if (is_shoot) begin
                    state_d      = ST_SHOOT_REQ;
                    last_shoot_d = 1'b1;
                end
            end
            ST_SHOOT_REQ, ST_WAIT_REL, ST_COOLDOWN: begin
                if (is_start) pend_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge master_clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            dir_q        <= 3'b100;
            err_q        <= 8'd0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            last_shoot_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ir_ready;
            dir_q        <= dir_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            last_shoot_q <= last_shoot_d;
        end
    end

    assign {stop, right, left} = dir_q;
    assign shoot_req = (state_q == ST_SHOOT_REQ);
    assign start_req = (state_q == ST_START_REQ);
    assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_cmd_ctrl
// Brief    : Directed plus random stimulus against a cycle-level model of the
//            IR command controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_ctrl;

    localparam int unsigned COOLDOWN = 100;

    logic        master_clk = 1'b0;
    logic        resetn;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic        cmd_ack;
    logic        left, right, stop, shoot_req, start_req;
    logic [7:0]  err_count;

    ir_cmd_ctrl #(.COOLDOWN(COOLDOWN)) dut (
        .master_clk (master_clk),
        .resetn     (resetn),
        .ir_ready   (ir_ready),
        .ir_data    (ir_data),
        .cmd_ack    (cmd_ack),
        .left       (left),
        .right      (right),
        .stop       (stop),
        .shoot_req  (shoot_req),
        .start_req  (start_req),
        .err_count  (err_count)
    );

    always #5 master_clk = ~master_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: which request is outstanding, whether we wait for ack release,
    // and how many cooldown cycles remain.
    bit       m_prev;
    bit [2:0] m_dir;
    int       m_err;
    int       m_req;       // 0 none, 1 shoot, 2 start
    bit       m_wait;
    bit       m_was_shoot;
    int       m_cool;
    bit       m_pend;
    bit       ack_lvl;

    function automatic void model_reset();
        m_prev = 0; m_dir = 3'b100; m_err = 0; m_req = 0;
        m_wait = 0; m_was_shoot = 0; m_cool = 0; m_pend = 0;
    endfunction

    function automatic void model_step(input bit rdy, input logic [31:0] d, input bit ack);
        bit ev, ok, idle;
        logic [7:0] k;
        ev = rdy && !m_prev;
        m_prev = rdy;
        k = d[23:16];
        ok = (d[31:24] == ~k) && (k == 8'h04 || k == 8'h05 || k == 8'h06 ||
                                  k == 8'h02 || k == 8'h08);
        if (ev && !ok && m_err < 255) m_err++;
        if (ev && ok) m_dir = (k == 8'h04) ? 3'b001 : (k == 8'h06) ? 3'b010 : 3'b100;

        if (m_req != 0 && ack) begin
            m_was_shoot = (m_req == 1);
            m_req = 0;
            m_wait = 1;
        end else if (m_wait && !ack) begin
            m_wait = 0;
            if (m_was_shoot) m_cool = COOLDOWN;
        end else if (m_cool > 0) begin
            m_cool--;
        end

        idle = (m_req == 0) && !m_wait && (m_cool == 0);
        if (idle && m_pend) begin
            m_pend = 0;
            m_req = 2;
        end else if (ev && ok) begin
            if (idle) begin
                if (k == 8'h08)      m_req = 2;
                else if (k == 8'h05) m_req = 1;
            end else if (m_req != 2 && k == 8'h08) begin
                m_pend = 1;
            end
        end
    endfunction

    task automatic compare_all();
        check("left",      left,      m_dir[0]);
        check("right",     right,     m_dir[1]);
        check("stop",      stop,      m_dir[2]);
        check("shoot_req", shoot_req, m_req == 1);
        check("start_req", start_req, m_req == 2);
        check("err_count", err_count, m_err);
    endtask

    task automatic cyc(input bit rdy, input logic [31:0] d, input bit ack);
        ir_ready = rdy;
        ir_data  = d;
        cmd_ack  = ack;
        @(posedge master_clk);
        model_step(rdy, d, ack);
        @(negedge master_clk);
        compare_all();
    endtask

    task automatic send(input logic [31:0] d);
        cyc(1'b1, d, ack_lvl);
        cyc(1'b0, d, ack_lvl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, ir_data, ack_lvl);
    endtask

    logic [31:0] pool [8];

    initial begin
        pool[0] = 32'hFB04_0000; pool[1] = 32'hFA05_0000; pool[2] = 32'hF906_0000;
        pool[3] = 32'hFD02_0000; pool[4] = 32'hF708_0000; pool[5] = 32'h0004_0000;
        pool[6] = 32'hF30C_0000; pool[7] = 32'h0;

        resetn = 1'b0; ir_ready = 1'b0; ir_data = 32'h0; cmd_ack = 1'b0; ack_lvl = 0;
        model_reset();
        repeat (2) @(negedge master_clk);
        compare_all();
        check("reset_stop", stop, 1'b1);
        resetn = 1'b1;

        send(32'hFB04_1234);
        check("dir_left", {stop, right, left}, 3'b001);
        send(32'hF906_0000);
        check("dir_right", {stop, right, left}, 3'b010);

        send(32'hFA05_0000);
        check("shoot_asserted", shoot_req, 1'b1);
        idle(4);
        ack_lvl = 1; idle(2);
        check("shoot_cleared", shoot_req, 1'b0);
        ack_lvl = 0; idle(3);
        send(32'hFA05_0000);
        check("shoot_in_cooldown", shoot_req, 1'b0);
        idle(110);
        send(32'hFA05_0000);
        check("shoot_after_cooldown", shoot_req, 1'b1);
        ack_lvl = 1; idle(2); ack_lvl = 0; idle(105);

        send(32'hFA05_0000);
        send(32'hF708_0000);
        ack_lvl = 1; idle(2); ack_lvl = 0;
        idle(105);
        check("pending_start", start_req, 1'b1);
        ack_lvl = 1; idle(2); ack_lvl = 0; idle(3);

        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 32'h0004_0000 : 32'hF30C_0000);
        check("err_saturated", err_count, 8'd255);
        check("no_req_after_bad", {shoot_req, start_req}, 2'b00);

        send(32'hFA05_0000);
        idle(2);
        #2 resetn = 1'b0;
        #1;
        check("async_shoot_clr", shoot_req, 1'b0);
        check("async_stop", stop, 1'b1);
        model_reset();
        compare_all();
        @(negedge master_clk);
        resetn = 1'b1;
        send(32'hF708_0000);
        check("start_after_reset", start_req, 1'b1);
        ack_lvl = 1; idle(2); ack_lvl = 0; idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            int sel;
            sel = $urandom_range(0, 7);
            d = (sel == 7) ? $urandom : pool[sel];
            if ($urandom_range(0, 5) == 0) ack_lvl = !ack_lvl;
            cyc($urandom_range(0, 2) == 0, d, ack_lvl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
